correlation_vacc: RTL
=====================

CORRELATION_VACC -- requirements
Module: correlation_vacc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 37, meaning the width of each incoming power/correlation term (2*18+1).
REQ-002 SHALL have parameter DOUT_WIDTH, default 64, meaning the width of each accumulated output term.
REQ-003 SHALL have parameter VECTOR_LEN, default 64, meaning the number of FFT channels per spectrum, a power of two and at least 4.
REQ-004 SHALL have parameter ACC_WIDTH, default 16, meaning the width of the integration-length input.
REQ-005 SHALL have the port clk, input, 1 bit, meaning the single clock.
REQ-006 SHALL have the port rst, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-007 SHALL have the port din1_pow, input, DIN_WIDTH bits unsigned, meaning the r11 term.
REQ-008 SHALL have the port din2_pow, input, DIN_WIDTH bits unsigned, meaning the r22 term.
REQ-009 SHALL have the ports corr_re and corr_im, input, DIN_WIDTH bits signed each, meaning the r12 term.
REQ-010 SHALL have the port din_valid, input, 1 bit, meaning the sample qualifier for one channel.
REQ-011 SHALL have the port sync_in, input, 1 bit, meaning that the sample qualified with din_valid is channel 0 of a spectrum.
REQ-012 SHALL have the port acc_len, input, ACC_WIDTH bits, meaning the number of spectra to integrate.
REQ-013 SHALL have the ports r11, r22, r12_re and r12_im, output, DOUT_WIDTH bits each (r11 and r22 unsigned, r12_re and r12_im signed), meaning the integrated terms.
REQ-014 SHALL have the port dout_chan, output, log2(VECTOR_LEN) bits, meaning the channel index of the current output.
REQ-015 SHALL have the port dout_valid, output, 1 bit, meaning the output qualifier.
REQ-016 SHALL have the port dout_last, output, 1 bit, meaning the output is channel VECTOR_LEN-1.

Function
REQ-017 SHALL implement two states: WAIT_SYNC (the reset state) and ACCUM.
REQ-018 SHALL ignore all samples in WAIT_SYNC until din_valid&sync_in, which enters ACCUM with chan=0, frame=0, and acc_len latched as L (acc_len=0 is treated as 1).
REQ-019 SHALL increment chan on each din_valid in ACCUM; on a wrap from VECTOR_LEN-1 to 0, frame SHALL increment, and after frame L-1 it SHALL restart at 0 and re-latch acc_len.
REQ-020 SHALL, per channel, write the input terms (sign/zero-extended to DOUT_WIDTH) to the BRAM when frame==0, otherwise BRAM content plus input; overflow wraps modulo 2^DOUT_WIDTH with no saturation.
REQ-021 SHALL, when frame==L-1, drive the new sum on the outputs with dout_valid=1 and dout_chan=chan exactly 3 clk after the qualifying din_valid.
REQ-022 SHALL keep dout_valid low for frames other than L-1.
REQ-023 SHALL assert dout_last together with dout_valid for chan VECTOR_LEN-1 only.
REQ-024 SHALL accept back-to-back din_valid at full rate with no read-after-write hazard; same-address reuse is at least VECTOR_LEN>=4 cycles apart, and writes SHALL be forwarded if pipeline depth requires.
REQ-025 SHALL tolerate din_valid gaps of any length, with no state change while din_valid is low.
REQ-026 SHALL handle sync_in with din_valid while chan!=0 in ACCUM as a resync: chan=0, frame=0, acc_len re-latched, partial integration discarded, and no dout_valid for the aborted spectrum.
REQ-027 SHALL ignore sync_in asserted at chan==0.
REQ-028 SHALL ignore sync_in without din_valid.
REQ-029 SHALL NOT affect an integration in progress when acc_len changes mid-integration.

Reset
REQ-030 SHALL, on rst low, asynchronously force WAIT_SYNC, chan=0, frame=0, r11=r22=r12_re=r12_im=0, dout_chan=0, dout_valid=0, dout_last=0, and empty the in-flight pipeline.
REQ-031 SHALL NOT clear BRAM contents on reset, since frame==0 overwrites them.
REQ-032 SHALL produce no output from samples accepted before a reset asserted mid-integration.

Structure
REQ-033 SHALL place the shared constants (term count = 4, pipeline latency = 3, default widths) in a shared package corr_pkg.
REQ-034 SHALL use one sub-module, sdp_bram (simple dual-port, 1-cycle read, width 2*DIN-independent 4*DOUT_WIDTH, depth VECTOR_LEN).

Verification
REQ-035 SHALL cover: VECTOR_LEN=4, acc_len=1, sync then din1_pow=5, din2_pow=7, corr=(-3,2) on all channels -> dout_valid on every sample, r11=5, r22=7, r12=(-3,2), dout_last on chan 3, 3-cycle latency.
REQ-036 SHALL cover: acc_len=3 with constant input 10 on all terms -> no dout_valid in spectra 0 and 1; spectrum 2 outputs 30 per channel; spectrum 3 starts a fresh sum.
REQ-037 SHALL cover: corr_re=-(2^(DIN_WIDTH-1)) for 2 spectra with acc_len=2 -> r12_re=-2^DIN_WIDTH (correct sign extension).
REQ-038 SHALL cover: sync_in at chan 2 of spectrum 1 with acc_len=2 -> no output for the aborted integration, and the next two full spectra output correct sums.
REQ-039 SHALL cover: random din_valid gaps with acc_len=4 -> results equal to a golden model, chan order preserved.
REQ-040 SHALL cover: rst pulled low mid-frame -> outputs 0 immediately, input ignored until next sync_in, first result after sync excludes pre-reset data.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared constants and types for the correlation vector accumulator.
package corr_pkg;

    localparam int unsigned NUM_TERMS      = 4;
    localparam int unsigned PIPE_LATENCY   = 3;
    localparam int unsigned DEF_DIN_WIDTH  = 37;
    localparam int unsigned DEF_DOUT_WIDTH = 64;
    localparam int unsigned DEF_VECTOR_LEN = 64;
    localparam int unsigned DEF_ACC_WIDTH  = 16;

    typedef enum logic {
        WAIT_SYNC,
        ACCUM
    } state_e;

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module sdp_bram #(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents are always overwritten before first use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/correlation_vacc.sv
// Per-channel vector accumulator for r11/r22/r12 terms; emits sums on the last spectrum
// of each integration, three clocks after the qualifying sample.
module correlation_vacc
    import corr_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int unsigned VECTOR_LEN = DEF_VECTOR_LEN,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIN_WIDTH-1:0]          din1_pow,
    input  logic [DIN_WIDTH-1:0]          din2_pow,
    input  logic signed [DIN_WIDTH-1:0]   corr_re,
    input  logic signed [DIN_WIDTH-1:0]   corr_im,
    input  logic                          din_valid,
    input  logic                          sync_in,
    input  logic [ACC_WIDTH-1:0]          acc_len,
    output logic [DOUT_WIDTH-1:0]         r11,
    output logic [DOUT_WIDTH-1:0]         r22,
    output logic signed [DOUT_WIDTH-1:0]  r12_re,
    output logic signed [DOUT_WIDTH-1:0]  r12_im,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_chan,
    output logic                          dout_valid,
    output logic                          dout_last
);

    localparam int unsigned CW  = $clog2(VECTOR_LEN);
    localparam int unsigned BW  = NUM_TERMS * DOUT_WIDTH;
    localparam int unsigned EXT = DOUT_WIDTH - DIN_WIDTH;

    state_e               r_state;
    logic [CW-1:0]        r_chan;
    logic [ACC_WIDTH-1:0] r_frame, r_len;

    logic                 w_accept, w_restart, w_last;
    logic [CW-1:0]        w_chan;
    logic [ACC_WIDTH-1:0] w_frame, w_len, w_acc_len;
    logic [BW-1:0]        w_din_ext, w_rd_data, w_sum;

    logic                 r_s1_valid, r_s1_first, r_s1_last;
    logic [CW-1:0]        r_s1_chan;
    logic [BW-1:0]        r_s1_din;
    logic                 r_s2_valid;
    logic [CW-1:0]        r_s2_chan;
    logic [BW-1:0]        r_s2_sum;

    // The sample carrying a restart is itself channel 0 of frame 0 under the new length.
    always_comb begin
        w_acc_len = (acc_len == '0) ? ACC_WIDTH'(1) : acc_len;
        w_accept  = din_valid && ((r_state == ACCUM) || sync_in);
        w_restart = din_valid && sync_in && ((r_state == WAIT_SYNC) || (r_chan != '0));
        w_chan    = w_restart ? '0 : r_chan;
        w_frame   = w_restart ? '0 : r_frame;
        w_len     = w_restart ? w_acc_len : r_len;
        w_last    = (w_frame == w_len - ACC_WIDTH'(1));
        w_din_ext = {{{EXT{corr_im[DIN_WIDTH-1]}}, corr_im},
                     {{EXT{corr_re[DIN_WIDTH-1]}}, corr_re},
                     {{EXT{1'b0}}, din2_pow},
                     {{EXT{1'b0}}, din1_pow}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_SYNC;
            r_chan  <= '0;
            r_frame <= '0;
            r_len   <= ACC_WIDTH'(1);
        end else if (w_accept) begin
            r_state <= ACCUM;
            r_chan  <= w_chan + CW'(1);
            if (w_chan == CW'(VECTOR_LEN - 1)) begin
                if (w_last) begin
                    r_frame <= '0;
                    r_len   <= w_acc_len;
                end else begin
                    r_frame <= w_frame + ACC_WIDTH'(1);
                    r_len   <= w_len;
                end
            end else begin
                r_frame <= w_frame;
                r_len   <= w_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_chan  <= '0;
            r_s1_din   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= (w_frame == '0);
                r_s1_last  <= w_last;
                r_s1_chan  <= w_chan;
                r_s1_din   <= w_din_ext;
            end
        end
    end

    // Same-channel reuse is VECTOR_LEN samples apart, so the write always lands first.
    always_comb begin
        w_sum = '0;
        for (int unsigned t = 0; t < NUM_TERMS; t++) begin
            w_sum[t*DOUT_WIDTH +: DOUT_WIDTH] =
                (r_s1_first ? '0 : w_rd_data[t*DOUT_WIDTH +: DOUT_WIDTH]) +
                r_s1_din[t*DOUT_WIDTH +: DOUT_WIDTH];
        end
    end

    sdp_bram #(
        .WIDTH (BW),
        .DEPTH (VECTOR_LEN)
    ) u_bram (
        .clk       (clk),
        .i_wr_en   (r_s1_valid),
        .i_wr_addr (r_s1_chan),
        .i_wr_data (w_sum),
        .i_rd_en   (w_accept),
        .i_rd_addr (w_chan),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_chan  <= '0;
            r_s2_sum   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
                r_s2_chan <= r_s1_chan;
                r_s2_sum  <= w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_chan  <= '0;
            r11        <= '0;
            r22        <= '0;
            r12_re     <= '0;
            r12_im     <= '0;
        end else begin
            dout_valid <= r_s2_valid;
            dout_last  <= r_s2_valid && (r_s2_chan == CW'(VECTOR_LEN - 1));
            if (r_s2_valid) begin
                dout_chan <= r_s2_chan;
                r11       <= r_s2_sum[0 +: DOUT_WIDTH];
                r22       <= r_s2_sum[DOUT_WIDTH +: DOUT_WIDTH];
                r12_re    <= $signed(r_s2_sum[2*DOUT_WIDTH +: DOUT_WIDTH]);
                r12_im    <= $signed(r_s2_sum[3*DOUT_WIDTH +: DOUT_WIDTH]);
            end
        end
    end

endmodule
